// File: rtl/decode_stage_ctrl.sv
// decode_stage_ctrl: fetch->execute decode stage with RV32 immediate generation, opcode
// classification and a 2-entry skid buffer. Define DECODE_PERF_EN to add stall/bubble counters.

module decode_immgen (
  input  logic [31:0] instr,
  output logic [31:0] imm,
  output logic        illegal,
  output logic        is_fp
);
  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_CALC   = 7'b0110011,
    OP_FLOAD  = 7'b0000111,
    OP_FSTORE = 7'b0100111,
    OP_F      = 7'b1010011
  } opcode_e;

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{21{instr[31]}}, instr[30:25], instr[11:7]};
  assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};
  assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    is_fp   = 1'b0;
    case (instr[6:0])
      OP_LUI, OP_AUIPC:          imm = imm_u;
      OP_JAL:                    imm = imm_j;
      OP_JALR, OP_LOAD, OP_IMM:  imm = imm_i;
      OP_BRANCH:                 imm = imm_b;
      OP_STORE:                  imm = imm_s;
      OP_CALC:                   imm = '0;
      OP_FLOAD:  begin imm = imm_i; is_fp = 1'b1; end
      OP_FSTORE: begin imm = imm_s; is_fp = 1'b1; end
      OP_F:                      is_fp = 1'b1;
      default:                   illegal = 1'b1;
    endcase
  end
endmodule

module decode_stage_ctrl #(
  parameter int unsigned          XLEN     = 32,
  parameter logic [XLEN-1:0]      RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal,
  output logic            out_is_fp
`ifdef DECODE_PERF_EN
  ,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     bubble_cycles
`endif
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic            illegal;
    logic            is_fp;
  } entry_t;

  state_e      state_q, state_d;
  entry_t      head_q, head_d;
  entry_t      skid_q, skid_d;
  logic        in_ready_q, in_ready_d;
  entry_t      new_entry;
  logic [31:0] gen_imm;
  logic        gen_illegal, gen_is_fp;
  logic        in_fire, out_fire;

  decode_immgen u_immgen (
    .instr   (in_instr),
    .imm     (gen_imm),
    .illegal (gen_illegal),
    .is_fp   (gen_is_fp)
  );

  assign new_entry = '{instr: in_instr, pc: in_pc, imm: gen_imm,
                       illegal: gen_illegal, is_fp: gen_is_fp};

  // Ready comes from a flop; the rst mask only holds it low while reset is applied.
  assign in_ready  = in_ready_q & ~rst;
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  assign out_instr   = head_q.instr;
  assign out_pc      = head_q.pc;
  assign out_imm     = head_q.imm;
  assign out_illegal = head_q.illegal;
  assign out_is_fp   = head_q.is_fp;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (in_fire) begin
        state_d = ONE;
        head_d  = new_entry;
      end
      ONE: begin
        if (in_fire && out_fire) begin
          head_d = new_entry;
        end else if (in_fire) begin
          state_d = TWO;
          skid_d  = new_entry;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: if (out_fire) begin
        state_d = ONE;
        head_d  = skid_q;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
      head_d  = head_q;
      skid_d  = skid_q;
    end
    in_ready_d = (state_d != TWO);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      head_q     <= '{instr: 32'h0000_0013, pc: RESET_PC, imm: '0, illegal: 1'b0, is_fp: 1'b0};
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      head_q     <= head_d;
    end
  end

  // NOTE: skid storage needs no reset; it is only read after a capture has written it.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

`ifdef DECODE_PERF_EN
  logic [31:0] stall_q, stall_d, bubble_q, bubble_d;

  always_comb begin
    stall_d  = stall_q + {31'b0, out_valid & ~out_ready};
    bubble_d = bubble_q + {31'b0, ~out_valid};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign stall_cycles  = stall_q;
  assign bubble_cycles = bubble_q;
`endif
endmodule

// File: tb/tb_decode_stage_ctrl.sv
// Self-checking bench for decode_stage_ctrl: immediate vector table, hand-written
// backpressure/flush/reset sequences and a randomized run against a queue-based model.

module tb_decode_stage_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush;
  logic        out_valid, out_ready, out_illegal, out_is_fp;
  logic [31:0] in_instr, in_pc, out_instr, out_pc, out_imm;
`ifdef DECODE_PERF_EN
  logic [31:0] stall_cycles, bubble_cycles;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic        illegal;
    logic        is_fp;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        illegal;
    logic        is_fp;
  } ent_t;

  ent_t model_q[$];

  decode_stage_ctrl #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_imm     (out_imm),
    .out_illegal (out_illegal),
    .out_is_fp   (out_is_fp)
`ifdef DECODE_PERF_EN
    ,
    .stall_cycles  (stall_cycles),
    .bubble_cycles (bubble_cycles)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Two's-complement interpretation of a 'bits'-wide field, returned as 32 bits.
  function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
    logic [31:0] half = 32'd1 << (bits - 1);
    return (v >= half) ? v - (32'd1 << bits) : v;
  endfunction

  function automatic ent_t ref_entry(input logic [31:0] i, input logic [31:0] pc);
    ent_t e;
    logic [31:0] op = i & 32'h7F;
    e.instr = i; e.pc = pc; e.imm = 0; e.illegal = 0; e.is_fp = 0;
    case (op)
      32'h37, 32'h17: e.imm = (i >> 12) * 4096;
      32'h6F: e.imm = sx(((i >> 31) & 1) * (1 << 20) + ((i >> 12) & 255) * (1 << 12)
                         + ((i >> 20) & 1) * (1 << 11) + ((i >> 21) & 1023) * 2, 21);
      32'h67, 32'h03, 32'h13, 32'h07: e.imm = sx(i >> 20, 12);
      32'h23, 32'h27: e.imm = sx((i >> 25) * 32 + ((i >> 7) & 31), 12);
      32'h63: e.imm = sx(((i >> 31) & 1) * 4096 + ((i >> 7) & 1) * 2048
                         + ((i >> 25) & 63) * 32 + ((i >> 8) & 15) * 2, 13);
      32'h33, 32'h53: e.imm = 0;
      default: e.illegal = 1;
    endcase
    e.is_fp = (op == 32'h07) || (op == 32'h27) || (op == 32'h53);
    return e;
  endfunction

  task automatic check_model(input string tag);
    check({tag, ".out_valid"}, out_valid, model_q.size() > 0);
    check({tag, ".in_ready"}, in_ready, model_q.size() < 2);
    if (model_q.size() > 0) begin
      check({tag, ".instr"}, out_instr, model_q[0].instr);
      check({tag, ".pc"}, out_pc, model_q[0].pc);
      check({tag, ".imm"}, out_imm, model_q[0].imm);
      check({tag, ".illegal"}, out_illegal, model_q[0].illegal);
      check({tag, ".is_fp"}, out_is_fp, model_q[0].is_fp);
    end
  endtask

  vec_t vecs[$];
  logic [6:0] legal_ops [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                 7'h23, 7'h13, 7'h33, 7'h07, 7'h27, 7'h53};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;

    // Reset state
    step();
    check("rst.out_valid", out_valid, 0);
    check("rst.in_ready", in_ready, 0);
    check("rst.out_instr", out_instr, 32'h0000_0013);
    check("rst.out_pc", out_pc, 32'h0);
    check("rst.out_imm", out_imm, 32'h0);
    check("rst.out_illegal", out_illegal, 0);
    check("rst.out_is_fp", out_is_fp, 0);
    rst = 1'b0;
    step();
    check("post_rst.in_ready", in_ready, 1);
    check("post_rst.out_valid", out_valid, 0);

    // Single-instruction vectors with hand-derived immediates
    vecs = '{
      '{32'hFFF0_0093, 32'hFFFF_FFFF, 1'b0, 1'b0},  // addi x1,x0,-1
      '{32'h1234_50B7, 32'h1234_5000, 1'b0, 1'b0},  // lui
      '{32'hFFFF_F017, 32'hFFFF_F000, 1'b0, 1'b0},  // auipc
      '{32'hFFDF_F06F, 32'hFFFF_FFFC, 1'b0, 1'b0},  // jal -4
      '{32'h8000_0067, 32'hFFFF_F800, 1'b0, 1'b0},  // jalr -2048
      '{32'h0000_0463, 32'h0000_0008, 1'b0, 1'b0},  // beq +8
      '{32'hFE00_0EE3, 32'hFFFF_FFFC, 1'b0, 1'b0},  // beq -4
      '{32'h00B0_2423, 32'h0000_0008, 1'b0, 1'b0},  // sw
      '{32'h0020_81B3, 32'h0000_0000, 1'b0, 1'b0},  // add
      '{32'h0000_007F, 32'h0000_0000, 1'b1, 1'b0},  // illegal
      '{32'h0000_0010, 32'h0000_0000, 1'b1, 1'b0},  // bad low bits
      '{32'h0005_2007, 32'h0000_0000, 1'b0, 1'b1},  // flw
      '{32'h00A5_2427, 32'h0000_0008, 1'b0, 1'b1},  // fsw
      '{32'h0000_0053, 32'h0000_0000, 1'b0, 1'b1}   // fadd.s
    };
    out_ready = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      in_valid = 1'b1; in_instr = vecs[i].instr; in_pc = 32'h100 + 32'(i) * 4;
      step();
      in_valid = 1'b0;
      check($sformatf("vec%0d.out_valid", i), out_valid, 1);
      check($sformatf("vec%0d.instr", i), out_instr, vecs[i].instr);
      check($sformatf("vec%0d.pc", i), out_pc, 32'h100 + 32'(i) * 4);
      check($sformatf("vec%0d.imm", i), out_imm, vecs[i].imm);
      check($sformatf("vec%0d.illegal", i), out_illegal, vecs[i].illegal);
      check($sformatf("vec%0d.is_fp", i), out_is_fp, vecs[i].is_fp);
      step();
      check($sformatf("vec%0d.empty", i), out_valid, 0);
    end

    // Backpressure: three instrs with out_ready low, then drain
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0010_0093; in_pc = 32'h200;
    step();
    check("bp.a_valid", out_valid, 1);
    check("bp.a_pc", out_pc, 32'h200);
    check("bp.ready_one", in_ready, 1);
    in_instr = 32'h0020_0093; in_pc = 32'h204;
    step();
    check("bp.ready_two", in_ready, 0);
    check("bp.hold_a", out_pc, 32'h200);
    in_instr = 32'h0030_0093; in_pc = 32'h208;
    step();
    check("bp.stable_pc", out_pc, 32'h200);
    check("bp.stable_imm", out_imm, 32'h1);
    check("bp.still_full", in_ready, 0);
    out_ready = 1'b1;
    step();
    check("bp.b_pc", out_pc, 32'h204);
    check("bp.b_imm", out_imm, 32'h2);
    check("bp.ready_again", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("bp.c_pc", out_pc, 32'h208);
    check("bp.c_valid", out_valid, 1);
    step();
    check("bp.drained", out_valid, 0);

    // Flush while TWO with a same-cycle input
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0040_0093; in_pc = 32'h300;
    step();
    in_pc = 32'h304;
    step();
    check("fl.full", in_ready, 0);
    in_pc = 32'h308; in_instr = 32'h0050_0093; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl.out_valid", out_valid, 0);
    check("fl.in_ready", in_ready, 1);
    out_ready = 1'b1;
    step();
    check("fl.no_ghost", out_valid, 0);

    // Randomized run against the queue model
    model_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit do_in, do_out;
      check_model($sformatf("rnd%0d", cyc));
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      flush     = ($urandom_range(19) == 0);
      in_instr  = $urandom;
      if ($urandom_range(9) < 8) in_instr[6:0] = legal_ops[$urandom_range(11)];
      in_pc     = $urandom & 32'hFFFF_FFFC;
      do_in  = in_valid && (model_q.size() < 2);
      do_out = out_ready && (model_q.size() > 0);
      if (flush) begin
        model_q.delete();
      end else begin
        if (do_out) void'(model_q.pop_front());
        if (do_in) model_q.push_back(ref_entry(in_instr, in_pc));
      end
      step();
    end
    check_model("rnd_end");
    flush = 1'b1; in_valid = 1'b0;
    step();
    flush = 1'b0;

    // Reset while TWO, then counter behaviour
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0060_0093; in_pc = 32'h400;
    step();
    in_pc = 32'h404;
    step();
    check("rt.full", in_ready, 0);
    rst = 1'b1;
    step();
    check("rt.out_valid", out_valid, 0);
    check("rt.in_ready", in_ready, 0);
    check("rt.out_pc", out_pc, 32'h0);
    check("rt.out_instr", out_instr, 32'h0000_0013);
`ifdef DECODE_PERF_EN
    check("rt.stall_zero", stall_cycles, 0);
    check("rt.bubble_zero", bubble_cycles, 0);
`endif
    rst = 1'b0; in_valid = 1'b0;
    step();
    check("rt.ready_after", in_ready, 1);
    check("rt.empty_after", out_valid, 0);
`ifdef DECODE_PERF_EN
    check("rt.bubble_one", bubble_cycles, 1);
`endif
    in_valid = 1'b1; in_instr = 32'h0070_0093; in_pc = 32'h500;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    check("rt.held_valid", out_valid, 1);
    check("rt.held_pc", out_pc, 32'h500);
`ifdef DECODE_PERF_EN
    check("perf.stall_five", stall_cycles, 5);
    check("perf.bubble_two", bubble_cycles, 2);
`endif
    out_ready = 1'b1;
    step();
    check("rt.drained", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
